// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, Diff = A - B - Bin.
// One full-subtractor cell and a borrow flop handle one bit per clock, LSB first.
// A start/busy/done handshake frames each operation. Results and flags hold until
// the next operation completes.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request, sampled only while idle
//   A, B   minuend / subtrahend, captured on the accepted start edge
//   Bin    borrow-in, captured on the accepted start edge
//   Diff   registered result (wraps modulo 2^WIDTH)
//   Bout   final borrow, 1 when unsigned A < B + Bin
//   Ovf    signed overflow
//   Zero   1 when Diff == 0
//   busy   high while an operation is in flight
//   done   one-cycle completion pulse, WIDTH clocks after the start edge
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf,
  output logic             Zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_n;

  // Operand shift registers; bit 0 is the bit being processed this cycle.
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Partial result; the final bit is merged in combinationally on the last edge.
  logic [WIDTH-2:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  // Operand sign bits kept separately because the shift registers drain.
  logic             a_msb;
  logic             b_msb;

  logic             accept;
  logic             last;
  logic             d;
  logic             br_n;
  logic [WIDTH-1:0] res_n;
  logic             ovf_n;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic plus the full-subtractor cell.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    last    = 1'b0;
    d       = a_sr[0] ^ b_sr[0] ^ br;
    br_n    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    res_n   = {d, res_sr};
    ovf_n   = (a_msb ^ b_msb) & (res_n[WIDTH-1] ^ a_msb);
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      Diff   <= '0;
      Bout   <= 1'b0;
      Ovf    <= 1'b0;
      Zero   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sr   <= A;
        b_sr   <= B;
        br     <= Bin;
        a_msb  <= A[WIDTH-1];
        b_msb  <= B[WIDTH-1];
        res_sr <= '0;
        cnt    <= '0;
        busy   <= 1'b1;
      end else if (state == RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        br     <= br_n;
        res_sr <= res_n[WIDTH-1:1];
        cnt    <= cnt + CW'(1);
        if (last) begin
          Diff <= res_n;
          Bout <= br_n;
          Ovf  <= ovf_n;
          Zero <= (res_n == '0);
          done <= 1'b1;
          busy <= 1'b0;
          cnt  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor (WIDTH=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         Ovf;
  logic         Zero;
  logic         busy;
  logic         done;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
  } res_t;

  res_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .Diff (Diff),
    .Bout (Bout),
    .Ovf  (Ovf),
    .Zero (Zero),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic reference: widened subtraction, borrow is the sign of the wide result.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] t;
    res_t       r;
    t      = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
    r.diff = t[W-1:0];
    r.bout = t[W];
    r.ovf  = (a[W-1] != b[W-1]) && (r.diff[W-1] != a[W-1]);
    r.zero = (r.diff == '0);
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r.diff = Diff;
    r.bout = Bout;
    r.ovf  = Ovf;
    r.zero = Zero;
    return r;
  endfunction

  // Called on a falling edge; returns on the falling edge after the start edge.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                             input bit push);
    A     = a;
    B     = b;
    Bin   = bin;
    start = 1'b1;
    if (push) sb.push_back(model(a, b, bin));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    Bin   = 1'b0;
    #1;
    n_checks++;
    if ({Diff, Bout, Ovf, Zero, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got %b expected all zero", {Diff, Bout, Ovf, Zero, busy, done});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({Diff, Bout, Ovf, Zero, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b expected all zero", {Diff, Bout, Ovf, Zero, busy, done});
    end
  endtask

  // 5 - 3: latency, busy window and one-cycle done pulse.
  task automatic test_basic();
    res_t exp;
    drive_start(4'd5, 4'd3, 1'b0, 1'b1);
    for (int k = 0; k < W; k++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_busy_cycle%0d: busy=%b done=%b expected busy=1 done=0", k, busy, done);
      end
      if (k < W - 1) @(negedge clk);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency: done=%b busy=%b expected done=1 busy=0", done, busy);
    end
    exp = sb.pop_front();
    n_checks++;
    if (observed() !== exp) begin
      n_fail++;
      $display("FAIL basic_result: got %h expected %h", observed(), exp);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: done=%b expected 0", done);
    end
  endtask

  // Borrow, overflow and zero cases; outputs must hold during each run.
  task automatic test_cases();
    logic [W-1:0] va[3];
    logic [W-1:0] vb[3];
    res_t         prev;
    res_t         exp;
    va = '{4'd3, 4'd8, 4'd5};
    vb = '{4'd5, 4'd1, 4'd5};
    for (int i = 0; i < 3; i++) begin
      prev = observed();
      drive_start(va[i], vb[i], 1'b0, 1'b1);
      for (int k = 1; k < W; k++) begin
        @(negedge clk);
        n_checks++;
        if (observed() !== prev || done !== 1'b0) begin
          n_fail++;
          $display("FAIL case%0d_hold_k%0d: got %h done=%b expected %h done=0", i, k, observed(), done, prev);
        end
      end
      @(negedge clk);
      exp = sb.pop_front();
      n_checks++;
      if (done !== 1'b1 || observed() !== exp) begin
        n_fail++;
        $display("FAIL case%0d_result: got %h done=%b expected %h done=1", i, observed(), done, exp);
      end
      @(negedge clk);
    end
  endtask

  // Start asserted during the done cycle must be accepted with no bubble.
  task automatic test_back_to_back();
    res_t exp;
    int   n;
    drive_start(4'd5, 4'd5, 1'b0, 1'b1);
    wait_done(n);
    exp = sb.pop_front();
    n_checks++;
    if (n !== W || observed() !== exp) begin
      n_fail++;
      $display("FAIL b2b_first: cycles=%0d result=%h expected cycles=%0d result=%h", n, observed(), W, exp);
    end
    drive_start(4'd0, 4'd0, 1'b1, 1'b1);
    wait_done(n);
    exp = sb.pop_front();
    n_checks++;
    if (n !== W || observed() !== exp) begin
      n_fail++;
      $display("FAIL b2b_second: cycles=%0d result=%h expected cycles=%0d result=%h", n, observed(), W, exp);
    end
    for (int i = 0; i < 8; i++) begin
      drive_start(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
      wait_done(n);
      exp = sb.pop_front();
      n_checks++;
      if (n !== W || observed() !== exp) begin
        n_fail++;
        $display("FAIL b2b_rand%0d: cycles=%0d result=%h expected cycles=%0d result=%h", i, n, observed(), W, exp);
      end
    end
    @(negedge clk);
  endtask

  // A second start while busy neither recaptures operands nor shifts timing.
  task automatic test_ignore_start();
    res_t exp;
    int   n;
    drive_start(4'd6, 4'd2, 1'b0, 1'b1);
    @(negedge clk);
    A     = 4'd1;
    B     = 4'd1;
    Bin   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    exp = sb.pop_front();
    n_checks++;
    if (n !== W - 2 || observed() !== exp) begin
      n_fail++;
      $display("FAIL ignore_result: cycles=%0d result=%h expected cycles=%0d result=%h", n, observed(), W - 2, exp);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL ignore_no_restart_k%0d: done=%b busy=%b expected 0 0", k, done, busy);
      end
    end
  endtask

  // Reset mid-run clears outputs immediately and suppresses done.
  task automatic test_reset_abort();
    res_t exp;
    int   n;
    drive_start(4'd9, 4'd4, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({Diff, Bout, Ovf, Zero, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL abort_clear: got %b expected all zero", {Diff, Bout, Ovf, Zero, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done_k%0d: done=%b busy=%b expected 0 0", k, done, busy);
      end
    end
    drive_start(4'd7, 4'd2, 1'b1, 1'b1);
    wait_done(n);
    exp = sb.pop_front();
    n_checks++;
    if (n !== W || observed() !== exp) begin
      n_fail++;
      $display("FAIL abort_recover: cycles=%0d result=%h expected cycles=%0d result=%h", n, observed(), W, exp);
    end
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cases();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
